// File: rtl/flatten_stream_ctrl.sv
// flatten_stream_ctrl: element-serial sequencer between the max-pool and
// fully-connected layers. Forward passes tag each CHW-raster element with its
// 1D FC index; backward passes tag each 1D gradient with its (ch,row,col).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and a held element keeps its
// payload stable until it is taken.
module flatten_stream_ctrl #(
   parameter int WIDTH       = 16,
   parameter int CHANNELS    = 2,
   parameter int DIM3_WIDTH  = 4,
   parameter int DIM3_HEIGHT = 4,
   parameter int DIM1_LENGTH = CHANNELS * DIM3_WIDTH * DIM3_HEIGHT,
   localparam int IW = (DIM1_LENGTH > 1) ? $clog2(DIM1_LENGTH) : 1,
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int RW = (DIM3_HEIGHT > 1) ? $clog2(DIM3_HEIGHT) : 1,
   localparam int KW = (DIM3_WIDTH > 1) ? $clog2(DIM3_WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             dir,
   input  logic             layout,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [IW-1:0]    out_idx,
   output logic [CW-1:0]    out_ch,
   output logic [RW-1:0]    out_row,
   output logic [KW-1:0]    out_col,
   output logic [1:0]       fsm_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   // Counts run to N inclusive, so they need one bit more than an index.
   localparam int CNTW = IW + 1;
   localparam logic [CNTW-1:0] N_CNT    = CNTW'(DIM1_LENGTH);
   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DIM1_LENGTH - 1);
   localparam logic [IW-1:0]   W_L      = IW'(DIM3_WIDTH);
   localparam logic [IW-1:0]   C_L      = IW'(CHANNELS);
   localparam logic [IW-1:0]   HW_L     = IW'(DIM3_WIDTH * DIM3_HEIGHT);
   localparam logic [CW-1:0]   CH_LAST  = CW'(CHANNELS - 1);
   localparam logic [RW-1:0]   ROW_LAST = RW'(DIM3_HEIGHT - 1);
   localparam logic [KW-1:0]   COL_LAST = KW'(DIM3_WIDTH - 1);

   state_t          state;
   logic            dir_q;
   logic            layout_q;
   logic [CW-1:0]   in_ch;
   logic [RW-1:0]   in_row;
   logic [KW-1:0]   in_col;
   logic [IW-1:0]   in_idx;
   logic [CNTW-1:0] acc_cnt;
   logic [CNTW-1:0] out_cnt;

   logic            in_fire;
   logic            out_fire;
   logic [IW-1:0]   chw_idx;
   logic [IW-1:0]   hwc_idx;
   logic [IW-1:0]   cur_idx;
   logic [CW-1:0]   nxt_ch;
   logic [RW-1:0]   nxt_row;
   logic [KW-1:0]   nxt_col;

   assign fsm_state = state;
   assign in_ready  = (state == RUN) && (acc_cnt < N_CNT) && (!out_valid || out_ready);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   // 1D index of the current input coordinate under each flatten layout.
   assign chw_idx = IW'(in_ch) * HW_L + IW'(in_row) * W_L + IW'(in_col);
   assign hwc_idx = (IW'(in_row) * W_L + IW'(in_col)) * C_L + IW'(in_ch);
   assign cur_idx = dir_q ? in_idx : (layout_q ? hwc_idx : chw_idx);

   // Next input coordinate: ch-fastest for backward HWC, col-fastest otherwise.
   always_comb begin
      nxt_ch  = in_ch;
      nxt_row = in_row;
      nxt_col = in_col;
      if (dir_q && layout_q) begin
         if (in_ch == CH_LAST) begin
            nxt_ch = '0;
            if (in_col == COL_LAST) begin
               nxt_col = '0;
               nxt_row = (in_row == ROW_LAST) ? '0 : in_row + RW'(1);
            end else begin
               nxt_col = in_col + KW'(1);
            end
         end else begin
            nxt_ch = in_ch + CW'(1);
         end
      end else begin
         if (in_col == COL_LAST) begin
            nxt_col = '0;
            if (in_row == ROW_LAST) begin
               nxt_row = '0;
               nxt_ch  = (in_ch == CH_LAST) ? '0 : in_ch + CW'(1);
            end else begin
               nxt_row = in_row + RW'(1);
            end
         end else begin
            nxt_col = in_col + KW'(1);
         end
      end
   end

   // Pass sequencing, input counters and the one-entry output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         dir_q     <= 1'b0;
         layout_q  <= 1'b0;
         in_ch     <= '0;
         in_row    <= '0;
         in_col    <= '0;
         in_idx    <= '0;
         acc_cnt   <= '0;
         out_cnt   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_ch    <= '0;
         out_row   <= '0;
         out_col   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  dir_q    <= dir;
                  layout_q <= layout;
                  in_ch    <= '0;
                  in_row   <= '0;
                  in_col   <= '0;
                  in_idx   <= '0;
                  acc_cnt  <= '0;
                  out_cnt  <= '0;
               end
            end
            RUN: begin
               if (abort) begin
                  // Abort wins over any handshake in the same cycle.
                  state     <= IDLE;
                  busy      <= 1'b0;
                  out_valid <= 1'b0;
                  out_data  <= '0;
                  out_idx   <= '0;
                  out_ch    <= '0;
                  out_row   <= '0;
                  out_col   <= '0;
               end else begin
                  if (in_fire) begin
                     out_valid <= 1'b1;
                     out_data  <= in_data;
                     out_idx   <= cur_idx;
                     out_ch    <= in_ch;
                     out_row   <= in_row;
                     out_col   <= in_col;
                     in_ch     <= nxt_ch;
                     in_row    <= nxt_row;
                     in_col    <= nxt_col;
                     in_idx    <= in_idx + IW'(1);
                     acc_cnt   <= acc_cnt + CNTW'(1);
                  end else if (out_fire) begin
                     out_valid <= 1'b0;
                  end
                  if (out_fire) begin
                     out_cnt <= out_cnt + CNTW'(1);
                     if (out_cnt == LAST_CNT) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flatten_stream_ctrl.sv
// Directed bench for flatten_stream_ctrl (CHANNELS=2, 4x4 maps, N=32).
module tb_flatten_stream_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        dir;
   logic        layout;
   logic        abort;
   logic        busy;
   logic        done;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [4:0]  out_idx;
   logic [0:0]  out_ch;
   logic [1:0]  out_row;
   logic [1:0]  out_col;
   logic [1:0]  fsm_state;

   int total = 0;
   int bad   = 0;

   // Captured output handshakes {data,idx,ch,row,col} and their negedge times.
   logic [25:0] cap_q[$];
   int          cap_t[$];
   logic [25:0] exp_q[$];
   int          neg_cnt  = 0;
   int          done_cnt = 0;
   int          done_at  = 0;

   flatten_stream_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dir       (dir),
      .layout    (layout),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_ch    (out_ch),
      .out_row   (out_row),
      .out_col   (out_col),
      .fsm_state (fsm_state)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Output monitor, sampled on the falling edge
   always @(negedge clk) begin
      neg_cnt = neg_cnt + 1;
      if (rst_n && out_valid && out_ready) begin
         cap_q.push_back({out_data, out_idx, out_ch, out_row, out_col});
         cap_t.push_back(neg_cnt);
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_at  = neg_cnt;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [25:0] pack(input int d, input int idx, input int ch,
                                        input int row, input int col);
      return {16'(d), 5'(idx), 1'(ch), 2'(row), 2'(col)};
   endfunction

   // Expected tuple for stream position i (value i+1).
   function automatic logic [25:0] expect_at(input logic d, input logic l, input int i);
      int ch;
      int row;
      int col;
      int idx;
      if (!d) begin
         ch  = i / 16;
         row = (i / 4) % 4;
         col = i % 4;
         idx = l ? ((row * 4 + col) * 2 + ch) : i;
      end else begin
         idx = i;
         if (l) begin
            ch  = i % 2;
            col = (i / 2) % 4;
            row = i / 8;
         end else begin
            ch  = i / 16;
            row = (i / 4) % 4;
            col = i % 4;
         end
      end
      return pack(i + 1, idx, ch, row, col);
   endfunction

   // Upstream driver: values 1..n, optional abort and stray start pulse
   task automatic stream_in(input int n, input int abort_at, input int glitch_at);
      int   sent;
      int   guard;
      logic fire;
      bit   glitched;
      sent     = 0;
      guard    = 0;
      glitched = 1'b0;
      while (sent < n && guard < 400) begin
         guard++;
         if (sent == abort_at) begin
            abort    = 1'b1;
            in_valid = 1'b1;
            in_data  = 16'(sent + 1);
            @(posedge clk);
            #1;
            abort    = 1'b0;
            in_valid = 1'b0;
            check("abort_state", 32'(fsm_state), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_out_valid", 32'(out_valid), 32'd0);
            check("abort_in_ready", 32'(in_ready), 32'd0);
            check("abort_out_data", 32'(out_data), 32'd0);
            return;
         end
         if (sent == glitch_at && !glitched) begin
            start    = 1'b1;
            glitched = 1'b1;
         end
         in_valid = 1'b1;
         in_data  = 16'(sent + 1);
         @(negedge clk);
         fire = in_ready;
         @(posedge clk);
         #1;
         start = 1'b0;
         if (fire) sent++;
      end
      in_valid = 1'b0;
      check("stream_budget", 32'(sent), 32'(n));
   endtask

   // Downstream driver: optional 3-cycle stall right after output #stall_after
   task automatic drive_ready(input int stall_after, input int base);
      int g;
      out_ready = 1'b1;
      if (stall_after < 0) return;
      g = 0;
      while ((cap_q.size() - base) < stall_after && g < 200) begin
         @(posedge clk);
         #1;
         g++;
      end
      check("stall_reached", 32'(cap_q.size() - base), 32'(stall_after));
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
         check($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("stall%0d_out_data", k), 32'(out_data), 32'(stall_after + 1));
         check($sformatf("stall%0d_out_idx", k), 32'(out_idx), 32'(stall_after));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
   endtask

   // Compare n captures from base against the expected queue
   task automatic compare_pass(input logic d, input logic l, input int base, input int n);
      logic [25:0] e;
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(expect_at(d, l, i));
      check("capture_count", 32'(cap_q.size() - base), 32'(n));
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         check($sformatf("elem%0d", i), 32'(cap_q[base + i]), 32'(e));
      end
   endtask

   // One pass: start, stream, and done/timing checks
   task automatic run_pass(input logic d, input logic l, input int abort_at,
                           input int glitch_at, input int stall_after, output int base);
      int t0;
      int dbase;
      int g;
      int last;
      base  = cap_q.size();
      dbase = done_cnt;
      out_ready = 1'b1;
      check("idle_in_ready", 32'(in_ready), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      dir    = d;
      layout = l;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      dir    = ~d;
      layout = ~l;
      check("run_busy", 32'(busy), 32'd1);
      check("run_state", 32'(fsm_state), 32'd1);
      check("run_out_valid", 32'(out_valid), 32'd0);
      t0 = neg_cnt;
      fork
         stream_in(32, abort_at, glitch_at);
         drive_ready(stall_after, base);
      join
      if (cap_q.size() > base) check("first_latency", 32'(cap_t[base]), 32'(t0 + 2));
      if (abort_at >= 0) begin
         repeat (4) begin
            @(posedge clk);
            #1;
         end
         check("abort_no_done", 32'(done_cnt - dbase), 32'd0);
         check("abort_idle", 32'(fsm_state), 32'd0);
      end else begin
         g = 0;
         while (done_cnt == dbase && g < 20) begin
            @(posedge clk);
            #1;
            g++;
         end
         check("done_busy_low", 32'(busy), 32'd0);
         repeat (3) begin
            @(posedge clk);
            #1;
         end
         check("done_pulses", 32'(done_cnt - dbase), 32'd1);
         check("post_idle", 32'(fsm_state), 32'd0);
         last = cap_t[cap_t.size() - 1];
         check("done_after_last", 32'(done_at), 32'(last + 1));
         if (stall_after < 0) check("full_rate", 32'(last - cap_t[base]), 32'd31);
      end
   endtask

   initial begin
      int b;
      int dbase;
      rst_n     = 1'b0;
      start     = 1'b0;
      dir       = 1'b0;
      layout    = 1'b0;
      abort     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #2;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_idx", 32'(out_idx), 32'd0);
      check("rst_state", 32'(fsm_state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Forward CHW
      run_pass(1'b0, 1'b0, -1, -1, -1, b);
      compare_pass(1'b0, 1'b0, b, 32);
      check("fchw_idx16", 32'(cap_q[b + 16]), 32'(pack(17, 16, 1, 0, 0)));

      // Forward HWC with a stray start mid-pass
      run_pass(1'b0, 1'b1, -1, 5, -1, b);
      compare_pass(1'b0, 1'b1, b, 32);
      check("fhwc_in18", 32'(cap_q[b + 17]), 32'(pack(18, 3, 1, 0, 1)));
      check("fhwc_in1", 32'(cap_q[b + 0]), 32'(pack(1, 0, 0, 0, 0)));
      check("fhwc_in17", 32'(cap_q[b + 16]), 32'(pack(17, 1, 1, 0, 0)));

      // Backward HWC
      run_pass(1'b1, 1'b1, -1, -1, -1, b);
      compare_pass(1'b1, 1'b1, b, 32);
      check("bhwc_idx5", 32'(cap_q[b + 5]), 32'(pack(6, 5, 1, 0, 2)));
      check("bhwc_idx8", 32'(cap_q[b + 8]), 32'(pack(9, 8, 0, 1, 0)));
      check("bhwc_idx31", 32'(cap_q[b + 31]), 32'(pack(32, 31, 1, 3, 3)));

      // Forward CHW with backpressure after the 10th output
      run_pass(1'b0, 1'b0, -1, -1, 10, b);
      compare_pass(1'b0, 1'b0, b, 32);

      // Abort after 7 accepts, then a backward CHW restart
      run_pass(1'b0, 1'b0, 7, -1, -1, b);
      compare_pass(1'b0, 1'b0, b, 7);
      run_pass(1'b1, 1'b0, -1, -1, -1, b);
      compare_pass(1'b1, 1'b0, b, 32);

      // Asynchronous reset in the middle of a pass
      out_ready = 1'b1;
      dir       = 1'b0;
      layout    = 1'b0;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'h00aa;
      repeat (5) @(posedge clk);
      #1;
      check("pre_rst_busy", 32'(busy), 32'd1);
      check("pre_rst_out_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_data", 32'(out_data), 32'd0);
      check("mid_rst_out_idx", 32'(out_idx), 32'd0);
      check("mid_rst_coord", 32'({out_ch, out_row, out_col}), 32'd0);
      check("mid_rst_state", 32'(fsm_state), 32'd0);
      in_valid = 1'b0;
      dbase    = done_cnt;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      check("rst_no_done", 32'(done_cnt - dbase), 32'd0);
      check("rst_idle", 32'(fsm_state), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
